// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller.
//   fetch_state_t : fetch FSM states (IDLE, ADDR, DATA, HOLD)
//   SIZE_WORD     : bus transfer size code for a 32-bit word
//   NOP_WORD      : instruction presented on an address-error fetch
//   RESET_VECTOR  : boot PC, shared with the PC register
//   KSEG01_TOP    : top two VA bits selecting kseg0/kseg1
package inst_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [1:0]  SIZE_WORD    = 2'b10;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR = 32'hbfc0_0000;
  localparam logic [1:0]  KSEG01_TOP   = 2'b10;

endpackage

// File: rtl/inst_fetch_ctrl_addr_map.sv
// inst_addr_map: combinational kseg0/kseg1 virtual-to-physical mapping.
// Addresses whose top two bits are 2'b10 have their top three bits cleared;
// all other addresses pass through unchanged.
// Ports:
//   vaddr  in  WIDTH  virtual fetch address
//   paddr  out WIDTH  physical fetch address
module inst_addr_map
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] vaddr,
  output logic [WIDTH-1:0] paddr
);

  always_comb begin
    paddr = vaddr;
    if (vaddr[WIDTH-1 -: 2] == KSEG01_TOP) begin
      paddr[WIDTH-1 -: 3] = 3'b000;
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: non-pipelined instruction-fetch controller.
// Issues one SRAM-like read per PC value, holds the returned instruction for
// decode and pulses the PC enable when the instruction is consumed. Flushes
// during a bus transaction are absorbed (the handshake completes and the data
// is dropped) so bus transactions are never aborted.
// Optional feature: define INST_KSEG_MAP_EN to present kseg0/kseg1-mapped
// physical addresses on inst_addr; otherwise inst_addr is pc_f unmapped.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   pc_f                       current PC from the PC register
//   d_stall, flush             decode back-pressure, redirect/exception
//   pc_en                      PC register enable
//   fetch_stall                high while no valid instruction is held
//   inst_f, inst_valid, adel_f fetched instruction, valid, address error
//   inst_req .. inst_wdata     bus request side (read-only, word size)
//   inst_addr_ok, inst_data_ok, inst_rdata  bus response side
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  NOP_INST = WIDTH'(NOP_WORD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_f,
  input  logic             d_stall,
  input  logic             flush,
  output logic             pc_en,
  output logic             fetch_stall,
  output logic [WIDTH-1:0] inst_f,
  output logic             inst_valid,
  output logic             adel_f,
  output logic             inst_req,
  output logic             inst_wr,
  output logic [1:0]       inst_size,
  output logic [WIDTH-1:0] inst_addr,
  output logic [WIDTH-1:0] inst_wdata,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata
);

  fetch_state_t     state;
  logic             cancel;
  logic             misaligned;
  logic [WIDTH-1:0] pc_phys;

  assign misaligned = |pc_f[1:0];

`ifdef INST_KSEG_MAP_EN
  inst_addr_map #(.WIDTH(WIDTH)) u_addr_map (
    .vaddr (pc_f),
    .paddr (pc_phys)
  );
`else
  assign pc_phys = pc_f;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      inst_f     <= '0;
      inst_valid <= 1'b0;
      adel_f     <= 1'b0;
      inst_req   <= 1'b0;
      inst_addr  <= '0;
      cancel     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A flush here means pc_f is being redirected; start on the new PC.
          if (!flush) begin
            if (misaligned) begin
              inst_f     <= NOP_INST;
              adel_f     <= 1'b1;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end else begin
              inst_addr <= pc_phys;
              inst_req  <= 1'b1;
              state     <= ADDR;
            end
          end
        end
        ADDR: begin
          if (flush) cancel <= 1'b1;
          if (inst_addr_ok) begin
            inst_req <= 1'b0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (inst_data_ok) begin
            // A flush arriving with the data counts as a cancel.
            if (cancel || flush) begin
              cancel <= 1'b0;
              state  <= IDLE;
            end else begin
              inst_f     <= inst_rdata;
              adel_f     <= 1'b0;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end
          end else if (flush) begin
            cancel <= 1'b1;
          end
        end
        HOLD: begin
          if (flush || !d_stall) begin
            inst_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pc_en       = flush | ((state == HOLD) & ~d_stall);
  assign fetch_stall = (state != HOLD);
  assign inst_wr     = 1'b0;
  assign inst_size   = SIZE_WORD;
  assign inst_wdata  = '0;

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Instruction-fetch controller that sits directly downstream of the PC register. It takes the current PC and issues one SRAM-like instruction read per PC value. It then holds the returned instruction for the decode stage and pulses the PC register's enable when the instruction has been consumed. Branch or exception flushes are absorbed here, so in-flight bus transactions are never aborted.

Parameters:
WIDTH, 32, address and data width (PC, bus address, instruction).
NOP_INST, 32'h00000000, instruction word presented on an address-error fetch.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
pc_f  in  WIDTH  current PC, from the PC register q
d_stall  in  1  decode stage cannot accept an instruction this cycle
flush  in  1  redirect or exception; discard the current fetch
pc_en  out  1  enable to the PC register
fetch_stall  out  1  high whenever no valid instruction is held
inst_f  out  WIDTH  fetched instruction
inst_valid  out  1  inst_f is valid
adel_f  out  1  fetch address error (pc_f[1:0] != 0)
inst_req  out  1  bus request
inst_wr  out  1  constant 0
inst_size  out  2  constant 2'b10 (word)
inst_addr  out  WIDTH  bus address, registered
inst_wdata  out  WIDTH  constant 0
inst_addr_ok  in  1  address accepted
inst_data_ok  in  1  read data valid
inst_rdata  in  WIDTH  read data

Behaviour:
- Reset state: IDLE.
- Reset values:
  - state=IDLE; inst_f=0; inst_valid=0; adel_f=0; inst_req=0; inst_addr=0; cancel=0.
  - Combinational outputs follow from state=IDLE with cancel=0.
- IDLE:
  - Aligned pc_f: latch inst_addr=pc_f, go to ADDR.
  - Misaligned pc_f: no bus request; latch inst_f=NOP_INST, adel_f=1, go to HOLD.
- ADDR:
  - inst_req=1.
  - Once asserted, inst_req and inst_addr must stay stable until inst_addr_ok.
  - On inst_addr_ok, go to DATA.
- DATA:
  - Wait for inst_data_ok; it never arrives in the same cycle as its inst_addr_ok.
  - On inst_data_ok with cancel=0: latch inst_f=inst_rdata, adel_f=0, go to HOLD.
  - On inst_data_ok with cancel=1: drop the data, clear cancel, go to IDLE.
- HOLD:
  - inst_valid=1.
  - If !d_stall: go to IDLE and clear inst_valid next cycle.
- pc_en = flush | (state==HOLD & !d_stall). This is a one-cycle pulse per consumed instruction.
- fetch_stall = (state != HOLD).
- Minimum fetch latency is 3 cycles from IDLE to HOLD (IDLE -> ADDR with addr_ok at once -> DATA with data_ok next cycle -> HOLD).
- Throughput is at most one instruction per 4 cycles; this block is intentionally non-pipelined.
- Flush:
  - In IDLE or HOLD: go to IDLE, inst_valid=0 next cycle.
  - In ADDR or DATA: set cancel=1 and keep the bus handshake going.
- Simultaneous events:
  - flush with inst_addr_ok: go to DATA with cancel=1.
  - flush with inst_data_ok: data discarded, go to IDLE.
  - flush with HOLD & !d_stall: pc_en=1 once, go to IDLE.
  - A second flush while cancel=1 has no additional effect.
- Reset mid-transaction: return to IDLE and clear cancel. The bus side is reset in the same cycle.

Optional Feature:
INST_KSEG_MAP_EN:
- Defined: inst_addr is the physical address. When pc_f[31:30]==2'b10 (kseg0/kseg1), inst_addr = {3'b000, pc_f[28:0]}; otherwise pc_f is passed unchanged.
- Undefined: inst_addr = pc_f, unmapped.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, ADDR, DATA, HOLD);
  - SIZE_WORD=2'b10;
  - NOP_INST;
  - reset vector 32'hbfc00000, shared with the PC register.
- One natural sub-module: inst_addr_map, combinational kseg mapping, instantiated only under INST_KSEG_MAP_EN.

Test Plan:
- Reset then pc_f=32'hbfc00000: inst_req rises 1 cycle after reset release. With addr_ok at once and data_ok next cycle, inst_rdata=32'h3c1d0001 appears on inst_f with inst_valid=1 three cycles after reset release, and pc_en pulses once.
- Slow bus (addr_ok after 3 cycles, data_ok after 5 more): inst_req and inst_addr stay stable, fetch_stall=1 throughout, inst_valid=0 until data_ok.
- d_stall=1 for 4 cycles in HOLD: inst_f is held, pc_en=0. When d_stall drops, exactly one pc_en pulse.
- flush one cycle after addr_ok: pc_en=1 that cycle. The returned data 32'hdeadbeef never appears on inst_f. The next fetch uses the new pc_f.
- pc_f=32'hbfc00002: no inst_req; inst_f=NOP_INST, adel_f=1, inst_valid=1.
- INST_KSEG_MAP_EN defined: pc_f=32'h9fc00010 gives inst_addr=32'h1fc00010. Undefined: inst_addr=32'h9fc00010.
